// File: rtl/booth_mac_accum_pkg.sv
// Shared types and constants for the Booth-product accumulator.
// Holds the FSM state encoding and default width/saturation constants.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int unsigned PW_DEF = 64;
  localparam int unsigned AW_DEF = 72;
  localparam int unsigned CW_DEF = 8;

  // Saturation limits for the default accumulator width
  localparam logic [AW_DEF-1:0] SAT_MAX_DEF = {1'b0, {(AW_DEF-1){1'b1}}};
  localparam logic [AW_DEF-1:0] SAT_MIN_DEF = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_mac_accum_sat_add.sv
// Combinational AW-bit signed adder with overflow flag and optional clamp.
module sat_add #(
  parameter int unsigned AW = 72
) (
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_b,
  input  logic          i_sat_en,
  output logic [AW-1:0] o_sum,
  output logic          o_ovf
);

  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  logic [AW:0] w_s;

  assign w_s   = {i_a[AW-1], i_a} + {i_b[AW-1], i_b};
  assign o_ovf = w_s[AW] ^ w_s[AW-1];

  always_comb begin
    o_sum = w_s[AW-1:0];
    if (i_sat_en && o_ovf) begin
      o_sum = w_s[AW] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates a programmable number of signed products into a wide sum,
// presented on a valid/ready port with a one-entry skid for stalled sums.
module booth_mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned PW = 64,
  parameter int unsigned AW = 72,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prod_valid,
  input  logic [PW-1:0] prod,
  input  logic [CW-1:0] cfg_len,
  input  logic          sat_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_sat,
  output logic          busy,
  output logic          drop_err,
  input  logic          clear_err
);

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic          r_sat;
  logic          r_skid_vld;
  logic [PW-1:0] r_skid;
  logic          r_out_valid;
  logic [AW-1:0] r_out_sum;
  logic          r_out_sat;
  logic          r_drop;

  logic                 w_hs;
  logic                 w_start;
  logic                 w_drop;
  logic signed [PW-1:0] w_src;
  logic signed [AW-1:0] w_b;
  logic [AW-1:0]        w_a;
  logic [AW-1:0]        w_sum;
  logic                 w_ovf;
  logic [CW-1:0]        w_len_new;
  logic [CW-1:0]        w_cnt_inc;

  assign w_hs    = (r_state == HOLD) && out_ready;
  assign w_start = ((r_state == IDLE) && prod_valid) ||
                   (w_hs && (r_skid_vld || prod_valid));
  assign w_drop  = (r_state == HOLD) && !out_ready && prod_valid && r_skid_vld;

  // A new sum is 0 + sext(src), so the same adder serves both start and add.
  assign w_src     = (w_hs && r_skid_vld) ? r_skid : prod;
  assign w_b       = AW'(w_src);
  assign w_a       = w_start ? '0 : r_acc;
  assign w_len_new = (cfg_len == '0) ? CW'(1) : cfg_len;
  assign w_cnt_inc = r_cnt + CW'(1);

  sat_add #(.AW(AW)) u_sat_add (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_sat_en (sat_en),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_sat       <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_sat   <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      if (w_start) begin
        r_len <= w_len_new;
        r_acc <= w_sum;
        r_cnt <= CW'(1);
        r_sat <= 1'b0;
        if (w_len_new == CW'(1)) begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
          r_out_sum   <= w_sum;
          r_out_sat   <= 1'b0;
        end else begin
          r_state     <= ACCUM;
          r_out_valid <= 1'b0;
        end
      end else begin
        case (r_state)
          ACCUM: begin
            if (prod_valid) begin
              r_acc <= w_sum;
              r_sat <= r_sat | w_ovf;
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == r_len) begin
                r_state     <= HOLD;
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum;
                r_out_sat   <= r_sat | w_ovf;
              end
            end
          end
          HOLD: begin
            if (w_hs) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // Skid: on handshake a full skid is consumed and refilled by a coincident
      // product; while stalled an empty skid captures the product.
      if (w_hs) begin
        r_skid_vld <= r_skid_vld && prod_valid;
        if (r_skid_vld && prod_valid) begin
          r_skid <= prod;
        end
      end else if ((r_state == HOLD) && prod_valid && !r_skid_vld) begin
        r_skid_vld <= 1'b1;
        r_skid     <= prod;
      end

      if (w_drop) begin
        r_drop <= 1'b1;
      end else if (clear_err) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_sat   = r_out_sat;
  assign busy      = (r_state != IDLE) || r_skid_vld;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed test of booth_mac_accum (default AW=72 and an AW=64 instance).
module tb_booth_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [63:0] prod;
  logic [7:0]  cfg_len;
  logic        sat_en;
  logic        out_ready;
  logic        clear_err;

  logic        out_valid, out_sat, busy, drop_err;
  logic [71:0] out_sum;
  logic        out_valid64, out_sat64, busy64, drop_err64;
  logic [63:0] out_sum64;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_mac_accum dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod),
    .cfg_len(cfg_len), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat),
    .busy(busy), .drop_err(drop_err), .clear_err(clear_err)
  );

  booth_mac_accum #(.PW(64), .AW(64), .CW(8)) dut64 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod),
    .cfg_len(cfg_len), .sat_en(sat_en), .out_valid(out_valid64),
    .out_ready(out_ready), .out_sum(out_sum64), .out_sat(out_sat64),
    .busy(busy64), .drop_err(drop_err64), .clear_err(clear_err)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [63:0] p);
    prod       = p;
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; prod_valid = 1'b0; prod = '0; cfg_len = 8'd1;
    sat_en = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    step(); step();
    check("rst_valid", 72'(out_valid), 72'd0);
    check("rst_sum",   out_sum, 72'd0);
    check("rst_sat",   72'(out_sat), 72'd0);
    check("rst_busy",  72'(busy), 72'd0);
    check("rst_drop",  72'(drop_err), 72'd0);
    rst = 1'b0;
    step();

    // 1: single product, len 1
    cfg_len = 8'd1; out_ready = 1'b1;
    pulse(64'd121);
    check("t1_valid", 72'(out_valid), 72'd1);
    check("t1_sum",   out_sum, 72'd121);
    check("t1_sat",   72'(out_sat), 72'd0);
    step();
    check("t1_idle_valid", 72'(out_valid), 72'd0);
    check("t1_idle_busy",  72'(busy), 72'd0);

    // 2: four products with gaps; cfg_len change mid-sum ignored
    cfg_len = 8'd4; out_ready = 1'b0;
    pulse(64'd121); step();
    cfg_len = 8'd1;
    pulse(-64'sd121); step(); step();
    check("t2_busy_mid", 72'(busy), 72'd1);
    pulse(64'd1000);
    check("t2_novalid3", 72'(out_valid), 72'd0);
    step();
    pulse(-64'sd5);
    check("t2_valid", 72'(out_valid), 72'd1);
    check("t2_sum",   out_sum, 72'd995);
    step();
    check("t2_stable", out_sum, 72'd995);
    out_ready = 1'b1;
    step();
    check("t2_done", 72'(out_valid), 72'd0);

    // 3: overflow on AW=64 instance, saturate then wrap
    cfg_len = 8'd2; sat_en = 1'b1;
    pulse(64'h7FFF_FFFF_FFFF_FFFF);
    pulse(64'h7FFF_FFFF_FFFF_FFFF);
    check("t3_sat_sum", 72'(out_sum64), 72'h7FFF_FFFF_FFFF_FFFF);
    check("t3_sat_flag", 72'(out_sat64), 72'd1);
    check("t3_wide_sum", out_sum, 72'h00_FFFF_FFFF_FFFF_FFFE);
    check("t3_wide_flag", 72'(out_sat), 72'd0);
    step();
    sat_en = 1'b0;
    pulse(64'h7FFF_FFFF_FFFF_FFFF);
    pulse(64'h7FFF_FFFF_FFFF_FFFF);
    check("t3_wrap_sum", 72'(out_sum64), 72'hFFFF_FFFF_FFFF_FFFE);
    check("t3_wrap_flag", 72'(out_sat64), 72'd1);
    step();
    check("t3_idle", 72'(out_valid64), 72'd0);

    // 4: stall, skid, drop, no-gap drain, clear
    cfg_len = 8'd1; out_ready = 1'b0;
    pulse(64'd7);
    pulse(64'd8);
    pulse(64'd9);
    check("t4_sum_held", out_sum, 72'd7);
    check("t4_valid",    72'(out_valid), 72'd1);
    check("t4_drop",     72'(drop_err), 72'd1);
    check("t4_busy",     72'(busy), 72'd1);
    out_ready = 1'b1;
    step();
    check("t4_next_valid", 72'(out_valid), 72'd1);
    check("t4_next_sum",   out_sum, 72'd8);
    step();
    check("t4_drained", 72'(out_valid), 72'd0);
    check("t4_busy_off", 72'(busy), 72'd0);
    check("t4_drop_sticky", 72'(drop_err), 72'd1);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("t4_cleared", 72'(drop_err), 72'd0);

    // 4b: drop and clear in the same cycle -> set wins
    out_ready = 1'b0;
    pulse(64'd1);
    pulse(64'd2);
    clear_err = 1'b1;
    pulse(64'd3);
    clear_err = 1'b0;
    check("t4b_set_wins", 72'(drop_err), 72'd1);
    out_ready = 1'b1;
    step();
    check("t4b_skid_sum", out_sum, 72'd2);
    step();
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("t4b_cleared", 72'(drop_err), 72'd0);

    // 5: cfg_len 0 acts as 1, negative sign-extended
    cfg_len = 8'd0;
    pulse(-64'sd3);
    check("t5_valid", 72'(out_valid), 72'd1);
    check("t5_sum",   out_sum, 72'hFF_FFFF_FFFF_FFFF_FFFD);
    step();

    // 6: async reset mid-sum, then clean sum of four
    cfg_len = 8'd4; out_ready = 1'b0;
    pulse(64'd5);
    pulse(64'd6);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 72'(out_valid), 72'd0);
    check("t6_rst_sum",   out_sum, 72'd0);
    check("t6_rst_busy",  72'(busy), 72'd0);
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(64'd1);
      check("t6_novalid", 72'(out_valid), 72'd0);
    end
    pulse(64'd1);
    check("t6_valid", 72'(out_valid), 72'd1);
    check("t6_sum",   out_sum, 72'd4);
    check("t6_sat",   72'(out_sat), 72'd0);
    step();
    check("t6_idle", 72'(busy), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mac_accum.md
Name: booth_mac_accum

Overview:
Downstream consumer of the 32-bit Booth signed multiplier. It captures each 64-bit signed product on the multiplier's done pulse and accumulates a programmable number of products into a wide signed sum, with optional saturation. It presents each finished sum on a valid/ready output port. A one-entry skid register absorbs a product that arrives while a finished sum is stalled.

Parameters:
PW, 64, product width (signed two's complement, from multiplier Result)
AW, 72, accumulator/sum width; must be >= PW
CW, 8, width of the per-sum product count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
prod_valid  input  1  one-cycle pulse: prod is a new product (multiplier Done)
prod  input  PW  signed product (multiplier Result)
cfg_len  input  CW  products per sum; sampled at the first product of each sum; 0 treated as 1
sat_en  input  1  1 = saturate on overflow, 0 = wrap; sampled every add
out_valid  output  1  finished sum available
out_ready  input  1  consumer accepts sum when out_valid & out_ready
out_sum  output  AW  finished signed sum; stable while out_valid & !out_ready
out_sat  output  1  overflow occurred during this sum; qualified by out_valid
busy  output  1  state != IDLE or skid full
drop_err  output  1  sticky: a product was lost
clear_err  input  1  clears drop_err

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, cnt=0, len=0, skid empty. Outputs: out_valid=0, out_sum=0, out_sat=0, busy=0, drop_err=0. Reset mid-sum discards everything, including the skid.
- States: IDLE, ACCUM, HOLD.
- "Start sum with p":
  - len = (cfg_len==0) ? 1 : cfg_len
  - acc = sext(p)
  - cnt = 1
  - sat flag = 0
  - next state = HOLD if len==1, else ACCUM
- IDLE:
  - prod_valid -> start sum with prod.
  - Otherwise remain in IDLE.
- ACCUM, on prod_valid:
  - s = sext(acc,AW+1) + sext(prod,AW+1).
  - On overflow (s[AW] != s[AW-1]), set the sat flag.
  - acc = sat_en ? clamp(s) to {0x7F..F, 0x80..0} : s[AW-1:0].
  - cnt++.
  - If the new cnt == len -> HOLD.
  - No prod_valid: hold state.
- HOLD:
  - out_valid=1, out_sum=acc, out_sat=sat flag.
  - Latency: the edge that adds the last product makes out_valid visible in the following cycle (1 cycle). For len==1, out_valid is high the cycle after prod_valid.
- HOLD handshake (out_valid & out_ready), priority order:
  - (a) Skid full -> start sum with skid. If prod_valid in the same cycle, prod refills the skid; otherwise the skid empties.
  - (b) Skid empty and prod_valid -> start sum with prod directly.
  - (c) Otherwise -> IDLE.
- HOLD without handshake, on prod_valid:
  - Skid empty -> prod written to skid.
  - Skid full -> prod dropped, drop_err set.
- drop_err:
  - Cleared by clear_err.
  - If clear_err and a drop occur in the same cycle, set wins.
- Invariants:
  - cnt never exceeds len.
  - out_sum/out_sat change only on reset or on HOLD entry.
  - cfg_len changes mid-sum have no effect.
  - sat_en is used per add, so changing it mid-sum affects only later adds.

Decomposition:
- Shared package mac_pkg:
  - state enum {IDLE, ACCUM, HOLD}
  - localparams for saturation limits, derived from AW
- One sub-module, sat_add: combinational AW-bit signed add with overflow flag and optional clamp. Reused for skid-start versus add-path selection.

Test Plan:
1. cfg_len=1, prod=121 (i.e. -11 x -11), out_ready=1 -> one cycle later out_valid=1, out_sum=121, out_sat=0; then IDLE, busy=0.
2. cfg_len=4; products 121, -121, 1000, -5 on non-consecutive cycles -> single out_valid with out_sum=995; no out_valid before the 4th product.
3. AW=64 override, cfg_len=2, two products 0x7FFF_FFFF_FFFF_FFFF:
   - sat_en=1 -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_sat=1
   - rerun with sat_en=0 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_sat=1
4. cfg_len=1, out_ready=0, then products 7, 8, 9 -> out_sum=7 held, 8 in skid, 9 dropped, drop_err=1. Raise out_ready -> next sum is 8, with no gap cycle. clear_err -> drop_err=0.
5. cfg_len=0, prod=-3 -> treated as len 1, out_sum=-3 (sign-extended to AW).
6. cfg_len=4; after 2 products, assert rst for 1 cycle -> all outputs 0, busy=0. Then 4 products of 1 -> out_sum=4 (no residue from before reset).
